// File: rtl/pipo_share_pkg.sv
// Shared constants for the PIPO share arbiter: FSM state codes and default build parameters.
package pipo_share_pkg;

    typedef logic state_t;

    localparam state_t ST_IDLE = 1'b0;
    localparam state_t ST_HOLD = 1'b1;

    localparam int DEF_N_REQ       = 4;
    localparam int DEF_WIDTH       = 4;
    localparam int DEF_HOLD_CYCLES = 2;

endpackage

// File: rtl/pipo_share_arbiter_rr_pick.sv
// Combinational rotating-priority selector: first asserted req at or after ptr, modulo N_REQ.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] oh,
    output logic [ID_W-1:0]  idx
);

    int j;

    // Walk offsets from farthest to nearest so the nearest asserted request overwrites last.
    always_comb begin
        oh  = '0;
        idx = '0;
        j   = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= N_REQ) j = j - N_REQ;
            if (req[j]) begin
                oh    = '0;
                oh[j] = 1'b1;
                idx   = ID_W'(j);
            end
        end
    end

endmodule

// File: rtl/pipo_share_arbiter.sv
// Round-robin front end for a shared PIPO register: one load per grant, then a fixed hold window.
module pipo_share_arbiter
    import pipo_share_pkg::*;
#(
    parameter int N_REQ       = DEF_N_REQ,
    parameter int WIDTH       = DEF_WIDTH,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int ID_W        = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] din,
    output logic [N_REQ-1:0]       gnt,
    output logic [WIDTH-1:0]       dout,
    output logic                   dout_valid,
    output logic [ID_W-1:0]        owner,
    output logic                   busy
);

    localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [ID_W-1:0]    ptr;
    logic [ID_W-1:0]    pick_idx;
    logic [N_REQ-1:0]   pick_oh;
    logic               xfer;

    rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_pick (
        .req (req),
        .ptr (ptr),
        .oh  (pick_oh),
        .idx (pick_idx)
    );

    assign xfer = |(req & gnt);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (xfer)      state_nxt = ST_HOLD;
            ST_HOLD: if (cnt == '0) state_nxt = ST_IDLE;
            default:                state_nxt = ST_IDLE;
        endcase
    end

    // Grant is gated by rst so nothing is offered while reset is held.
    always_comb begin
        gnt  = '0;
        busy = 1'b0;
        if (state == ST_HOLD) busy = 1'b1;
        else if (rst)         gnt  = pick_oh;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout       <= '0;
            owner      <= '0;
            dout_valid <= 1'b0;
            ptr        <= '0;
            cnt        <= '0;
        end else begin
            dout_valid <= xfer;
            if (xfer) begin
                dout  <= din[int'(pick_idx)*WIDTH +: WIDTH];
                owner <= pick_idx;
                ptr   <= (int'(pick_idx) == N_REQ - 1) ? '0 : pick_idx + 1'b1;
                cnt   <= CNT_W'(HOLD_CYCLES - 1);
            end else if (state == ST_HOLD && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipo_share_arbiter.sv
// Directed bench: HOLD_CYCLES=2 instance for the main scenarios plus a HOLD_CYCLES=1 instance.
module tb_pipo_share_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req, req1;
    logic [15:0] din;
    logic [3:0]  gnt, gnt1;
    logic [3:0]  dout, dout1;
    logic        dv, dv1;
    logic [1:0]  owner, owner1;
    logic        busy, busy1;

    int n_cmp = 0;
    int n_err = 0;

    logic [3:0] dat [4];

    always #5 clk = ~clk;

    pipo_share_arbiter #(.N_REQ(4), .WIDTH(4), .HOLD_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .req(req), .din(din), .gnt(gnt), .dout(dout),
        .dout_valid(dv), .owner(owner), .busy(busy)
    );

    pipo_share_arbiter #(.N_REQ(4), .WIDTH(4), .HOLD_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .req(req1), .din(din), .gnt(gnt1), .dout(dout1),
        .dout_valid(dv1), .owner(owner1), .busy(busy1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        dat[0] = 4'b1000; dat[1] = 4'b0100; dat[2] = 4'b0110; dat[3] = 4'b1010;
        rst  = 1'b0;
        req  = 4'hF;
        req1 = 4'h0;
        din  = {dat[3], dat[2], dat[1], dat[0]};
        tick; tick;
        chk("rst_gnt", gnt, 0);
        chk("rst_dout", dout, 0);
        chk("rst_owner", owner, 0);
        chk("rst_dv", dv, 0);
        chk("rst_busy", busy, 0);

        // All requesters continuous: 0,1,2,3,0 every 3 cycles
        rst = 1'b1;
        #1;
        for (int k = 0; k < 5; k++) begin
            chk("cont_gnt", gnt, 32'd1 << (k % 4));
            chk("cont_idle", busy, 0);
            tick;
            chk("cont_dout", dout, dat[k % 4]);
            chk("cont_owner", owner, k % 4);
            chk("cont_dv", dv, 1);
            chk("cont_busy1", busy, 1);
            chk("cont_gnt_hold", gnt, 0);
            tick;
            chk("cont_dv_off", dv, 0);
            chk("cont_busy2", busy, 1);
            tick;
        end

        // Pointer wrap: grant 3, then 1001 must pick 0
        req = 4'b1000;
        #1;
        chk("wrap_g3", gnt, 4'b1000);
        tick;
        chk("wrap_own3", owner, 3);
        req = 4'b1001;
        tick; tick;
        chk("wrap_g0", gnt, 4'b0001);
        tick;
        chk("wrap_own0", owner, 0);
        chk("wrap_dout0", dout, 4'b1000);

        // Requester 1 withdraws during HOLD
        req = 4'b0010;
        #1;
        chk("wd_gnt_hold", gnt, 0);
        tick;
        req = 4'b0000;
        chk("wd_busy", busy, 1);
        tick;
        chk("wd_gnt", gnt, 0);
        chk("wd_idle", busy, 0);
        tick;
        chk("wd_dout", dout, 4'b1000);
        chk("wd_owner", owner, 0);
        chk("wd_dv", dv, 0);

        // Single requester 2 with data 1010
        din[11:8] = 4'b1010;
        req = 4'b0100;
        #1;
        chk("one_gnt", gnt, 4'b0100);
        tick;
        req = 4'b0000;
        chk("one_dout", dout, 4'b1010);
        chk("one_owner", owner, 2);
        chk("one_dv", dv, 1);
        chk("one_busy1", busy, 1);
        tick;
        chk("one_busy2", busy, 1);
        chk("one_dv_off", dv, 0);
        tick;
        chk("one_busy_off", busy, 0);

        // Reset in the first HOLD cycle (ptr=3 so requester 3 wins)
        req = 4'hF;
        #1;
        chk("mid_gnt", gnt, 4'b1000);
        tick;
        chk("mid_dv_pre", dv, 1);
        rst = 1'b0;
        #1;
        chk("mid_dout", dout, 0);
        chk("mid_owner", owner, 0);
        chk("mid_dv", dv, 0);
        chk("mid_busy", busy, 0);
        chk("mid_gnt0", gnt, 0);
        tick;
        chk("mid_gnt_edge", gnt, 0);
        chk("mid_dout_edge", dout, 0);

        // HOLD_CYCLES=1 build: grant every 2 cycles
        rst  = 1'b1;
        req  = 4'h0;
        din  = {dat[3], dat[2], dat[1], dat[0]};
        req1 = 4'hF;
        #1;
        for (int k = 0; k < 5; k++) begin
            chk("h1_gnt", gnt1, 32'd1 << (k % 4));
            tick;
            chk("h1_dout", dout1, dat[k % 4]);
            chk("h1_owner", owner1, k % 4);
            chk("h1_dv", dv1, 1);
            chk("h1_busy", busy1, 1);
            tick;
            chk("h1_dv_off", dv1, 0);
            chk("h1_idle", busy1, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
